wb_arbiter_rr: RTL and testbench

- Round-robin Wishbone arbiter that shares the single master port of the Wishbone interconnect between WB_NUM_MASTERS requesters, e.g. CPU instruction fetch, CPU data and a DMA/debug master.
- Grants the bus for a whole Wishbone cycle, from cyc assertion to cyc release, and forwards the granted master's signals.
- A bus watchdog aborts cycles that no slave acknowledges and returns an error to the granted master.

---
 rtl/wb_arbiter_rr.sv | 165 ++++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: shares one master port between WB_NUM_MASTERS
// requesters for whole bus cycles, with a watchdog that aborts unacknowledged
// cycles and returns an error to the granted master.
module wb_arbiter_rr #(
    parameter int WB_DATA_WIDTH       = 32,
    parameter int WB_ADDR_WIDTH       = 32,
    parameter int WB_NUM_MASTERS      = 3,
    parameter int WB_NUM_MASTERS_BITS = 2,
    parameter int TIMEOUT_CYCLES      = 255,
    parameter int TIMEOUT_BITS        = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [WB_DATA_WIDTH*WB_NUM_MASTERS-1:0] m_dat_i,
    input  logic [WB_ADDR_WIDTH*WB_NUM_MASTERS-1:0] m_adr_i,
    input  logic [4*WB_NUM_MASTERS-1:0]             m_sel_i,
    input  logic [WB_NUM_MASTERS-1:0]               m_we_i,
    input  logic [WB_NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [WB_NUM_MASTERS-1:0]               m_stb_i,
    output logic [WB_DATA_WIDTH-1:0]                m_dat_o,
    output logic [WB_NUM_MASTERS-1:0]               m_ack_o,
    output logic [WB_NUM_MASTERS-1:0]               m_err_o,
    output logic [WB_DATA_WIDTH-1:0]                s_dat_o,
    output logic [WB_ADDR_WIDTH-1:0]                s_adr_o,
    output logic [3:0]                              s_sel_o,
    output logic                                    s_we_o,
    output logic                                    s_cyc_o,
    output logic                                    s_stb_o,
    input  logic [WB_DATA_WIDTH-1:0]                s_dat_i,
    input  logic                                    s_ack_i,
    output logic [WB_NUM_MASTERS-1:0]               grant_o,
    output logic                                    timeout_o
);

    localparam int NB = WB_NUM_MASTERS_BITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    // Watchdog count at which the current stb cycle is the last one allowed.
    localparam logic [TIMEOUT_BITS-1:0] WD_LAST =
        TIMEOUT_BITS'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [1:0]                state_q, state_d;
    logic [NB-1:0]             g_q, g_d;
    logic [NB-1:0]             last_q, last_d;
    logic [WB_NUM_MASTERS-1:0] grant_q, grant_d;
    logic [TIMEOUT_BITS-1:0]   wd_q, wd_d;
    logic                      timeout_q, timeout_d;

    logic [NB-1:0] rr_idx;
    logic          rr_found;
    logic [NB-1:0] mux_idx;
    logic          in_grant;
    logic          cyc_g;
    logic          stb_g;
    logic          wd_fire;

    // Round-robin search: first requester strictly after last, with wrap-around.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 1; i <= WB_NUM_MASTERS; i++) begin
            if (!rr_found && m_cyc_i[(int'(last_q) + i) % WB_NUM_MASTERS]) begin
                rr_found = 1'b1;
                rr_idx   = NB'((int'(last_q) + i) % WB_NUM_MASTERS);
            end
        end
    end

    // Datapath: master 0 is forwarded while idle; the granted master otherwise.
    assign mux_idx  = (state_q == ST_IDLE) ? '0 : g_q;
    assign in_grant = (state_q == ST_GRANT);
    assign cyc_g    = m_cyc_i[g_q];
    assign stb_g    = cyc_g & m_stb_i[g_q];

    assign s_cyc_o  = in_grant & cyc_g;
    assign s_stb_o  = in_grant & stb_g;
    assign s_we_o   = in_grant & cyc_g & m_we_i[g_q];
    assign s_adr_o  = m_adr_i[int'(mux_idx)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
    assign s_dat_o  = m_dat_i[int'(mux_idx)*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    assign s_sel_o  = m_sel_i[int'(mux_idx)*4 +: 4];
    assign m_dat_o  = s_dat_i;

    // The watchdog fires on the last allowed stb cycle; a same-cycle ack wins.
    assign wd_fire  = (TIMEOUT_CYCLES != 0) && s_stb_o && !s_ack_i && (wd_q == WD_LAST);

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

    // Route ack or watchdog error back to the granted master only.
    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (in_grant) begin
            m_ack_o[g_q] = s_ack_i & ~wd_fire;
            m_err_o[g_q] = wd_fire;
        end
    end

    // Next-state logic for the grant FSM, pointer and watchdog.
    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        last_d    = last_q;
        grant_d   = grant_q;
        wd_d      = '0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    state_d         = ST_GRANT;
                    g_d             = rr_idx;
                    last_d          = rr_idx;
                    grant_d         = '0;
                    grant_d[rr_idx] = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!cyc_g) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (wd_fire) begin
                    state_d   = ST_ABORT;
                    timeout_d = 1'b1;
                end else if (s_stb_o && !s_ack_i) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_ABORT: begin
                if (!cyc_g) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset; master 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q   <= ST_IDLE;
            g_q       <= '0;
            last_q    <= NB'(WB_NUM_MASTERS - 1);
            grant_q   <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed testbench for wb_arbiter_rr with three masters and a 4-cycle watchdog.
module tb_wb_arbiter_rr;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW*N-1:0] m_dat_i;
    logic [AW*N-1:0] m_adr_i;
    logic [4*N-1:0]  m_sel_i;
    logic [N-1:0]    m_we_i;
    logic [N-1:0]    m_cyc_i;
    logic [N-1:0]    m_stb_i;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o;
    logic [N-1:0]    m_err_o;
    logic [DW-1:0]   s_dat_o;
    logic [AW-1:0]   s_adr_o;
    logic [3:0]      s_sel_o;
    logic            s_we_o;
    logic            s_cyc_o;
    logic            s_stb_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;
    logic [N-1:0]    grant_o;
    logic            timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] adr_tbl [N] = '{32'h1000_0100, 32'h2000_0200, 32'h3000_0300};
    int          seq     [4] = '{1, 2, 0, 1};

    wb_arbiter_rr #(
        .WB_DATA_WIDTH      (DW),
        .WB_ADDR_WIDTH      (AW),
        .WB_NUM_MASTERS     (N),
        .WB_NUM_MASTERS_BITS(2),
        .TIMEOUT_CYCLES     (4),
        .TIMEOUT_BITS       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_dat_i  (m_dat_i),
        .m_adr_i  (m_adr_i),
        .m_sel_i  (m_sel_i),
        .m_we_i   (m_we_i),
        .m_cyc_i  (m_cyc_i),
        .m_stb_i  (m_stb_i),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_dat_o  (s_dat_o),
        .s_adr_o  (s_adr_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .grant_o  (grant_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] oh;
        rst     = 1'b1;
        m_adr_i = {adr_tbl[2], adr_tbl[1], adr_tbl[0]};
        m_dat_i = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        m_sel_i = {4'hC, 4'h3, 4'hF};
        m_we_i  = 3'b010;
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        s_dat_i = 32'h0;
        s_ack_i = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_timeout", 32'(timeout_o), 32'h0);
        chk("rst_ack_err", 32'({m_ack_o, m_err_o}), 32'h0);
        rst = 1'b0;

        // Single read by master 0, slave acks in the 2nd stb cycle
        tick();
        m_cyc_i = 3'b001;
        m_stb_i = 3'b001;
        #1;
        chk("t1_idle_cyc", 32'(s_cyc_o), 32'h0);
        chk("t1_idle_adr", s_adr_o, adr_tbl[0]);
        tick();
        chk("t1_grant", 32'(grant_o), 32'h1);
        chk("t1_cyc", 32'({s_cyc_o, s_stb_o}), 32'h3);
        chk("t1_adr", s_adr_o, 32'h1000_0100);
        chk("t1_sel", 32'(s_sel_o), 32'hF);
        chk("t1_noack", 32'(m_ack_o), 32'h0);
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        #1;
        chk("t1_ack", 32'(m_ack_o), 32'h1);
        chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
        tick();
        s_ack_i = 1'b0;
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        #1;
        chk("t1_hold_grant", 32'(grant_o), 32'h1);
        chk("t1_drop_cyc", 32'(s_cyc_o), 32'h0);
        tick();
        chk("t1_release", 32'(grant_o), 32'h0);

        // All masters requesting: rotation 1,2,0,1 with one idle cycle between grants
        for (int k = 0; k < 4; k++) begin
            oh      = 3'(1 << seq[k]);
            m_cyc_i = 3'b111;
            m_stb_i = 3'b111;
            #1;
            chk($sformatf("t2_idle_%0d", k), 32'(grant_o), 32'h0);
            tick();
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("t2_grant_%0d", k), 32'(grant_o), 32'(oh));
            chk($sformatf("t2_adr_%0d", k), s_adr_o, adr_tbl[seq[k]]);
            chk($sformatf("t2_we_%0d", k), 32'(s_we_o), 32'(seq[k] == 1));
            chk($sformatf("t2_ack_%0d", k), 32'(m_ack_o), 32'(oh));
            tick();
            s_ack_i = 1'b0;
            m_cyc_i = 3'b111 & ~oh;
            m_stb_i = 3'b111 & ~oh;
            #1;
            chk($sformatf("t2_drop_%0d", k), 32'(s_cyc_o), 32'h0);
            tick();
        end
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        tick();

        // Master 1 four-beat burst while master 2 waits
        m_cyc_i = 3'b010;
        m_stb_i = 3'b010;
        tick();
        m_cyc_i = 3'b110;
        m_stb_i = 3'b110;
        s_ack_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk($sformatf("t3_grant_%0d", b), 32'(grant_o), 32'h2);
            chk($sformatf("t3_ack_%0d", b), 32'(m_ack_o), 32'h2);
            tick();
        end
        s_ack_i = 1'b0;
        m_cyc_i = 3'b100;
        m_stb_i = 3'b100;
        #1;
        chk("t3_last_hold", 32'(grant_o), 32'h2);
        tick();
        chk("t3_gap", 32'(grant_o), 32'h0);
        tick();
        chk("t3_m2_grant", 32'(grant_o), 32'h4);
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        tick();
        tick();

        // Watchdog abort: slave never acks master 0
        m_cyc_i = 3'b001;
        m_stb_i = 3'b001;
        tick();
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("t4_err_c%0d", c), 32'(m_err_o), (c == 4) ? 32'h1 : 32'h0);
            chk($sformatf("t4_cyc_c%0d", c), 32'(s_cyc_o), 32'h1);
            tick();
        end
        s_ack_i = 1'b1;
        #1;
        chk("t4_abort_cyc", 32'({s_cyc_o, s_stb_o}), 32'h0);
        chk("t4_timeout", 32'(timeout_o), 32'h1);
        chk("t4_abort_grant", 32'(grant_o), 32'h1);
        chk("t4_late_ack", 32'({m_ack_o, m_err_o}), 32'h0);
        tick();
        s_ack_i = 1'b0;
        #1;
        chk("t4_pulse_once", 32'(timeout_o), 32'h0);
        chk("t4_still_abort", 32'(grant_o), 32'h1);
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        tick();
        chk("t4_idle", 32'(grant_o), 32'h0);

        // Ack in the 4th stb cycle beats the watchdog (master 1)
        m_cyc_i = 3'b010;
        m_stb_i = 3'b010;
        tick();
        tick();
        tick();
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("t5_ack", 32'(m_ack_o), 32'h2);
        chk("t5_err", 32'(m_err_o), 32'h0);
        tick();
        s_ack_i = 1'b0;
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        #1;
        chk("t5_timeout", 32'(timeout_o), 32'h0);
        tick();

        // Reset during a burst of master 2
        m_cyc_i = 3'b100;
        m_stb_i = 3'b100;
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("t6_ack", 32'(m_ack_o), 32'h4);
        rst     = 1'b1;
        m_cyc_i = 3'b101;
        m_stb_i = 3'b101;
        tick();
        chk("t6_rst_grant", 32'(grant_o), 32'h0);
        chk("t6_rst_cyc", 32'(s_cyc_o), 32'h0);
        chk("t6_rst_ack", 32'(m_ack_o), 32'h0);
        rst     = 1'b0;
        s_ack_i = 1'b0;
        tick();
        chk("t6_m0_first", 32'(grant_o), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
